motor_pwm_multi: RTL
====================

// Module: motor_pwm_multi
// PURPOSE
//   N-channel motor PWM driver, next generation of the fixed 2-channel motor_pwm/PWM_gen path.
//   - Shared period counter; per-channel duty targets are loaded through a valid/ready command port.
//   - Per-channel slew-limited ramping (soft start/stop) and direction control with safe reversal.
//   - Global emergency stop.
//   - Sits between the drive-mode logic (speed/stuck decisions) and the motor H-bridge pins.
// PARAMETERS
//   N_CH      2     number of motor channels (1..8)
//   DUTY_W    10    duty command width; duty/2^DUTY_W = on-fraction
//   CNT_W     12    period counter width; must satisfy 2^CNT_W > PERIOD
//   PERIOD    4000  clk cycles per PWM period (100 MHz / 25 kHz)
//   RAMP_STEP 8     max change of applied duty per PWM period, in duty LSBs (>=1)
// PORTS
//   clk        in   1                clock
//   reset      in   1                asynchronous, active-high
//   cmd_valid  in   1                command valid
//   cmd_ready  out  1                command accepted when cmd_valid && cmd_ready
//   cmd_ch     in   max(1,$clog2(N_CH))  target channel; values >= N_CH are accepted and dropped
//   cmd_duty   in   DUTY_W           target duty
//   cmd_dir    in   1                target direction (0 fwd, 1 rev)
//   estop      in   1                emergency stop, level, synchronous sense
//   pwm        out  N_CH             PWM outputs, registered
//   dir        out  N_CH             applied direction per channel, registered
//   at_target  out  N_CH             1 when applied duty==target and applied dir==target dir
//   period_tick out 1                one-cycle pulse on the last cycle of every period
// BEHAVIOUR
//   Reset values: pwm=0, dir=0, at_target=all 1, period_tick=0, cmd_ready=0.
//     Counter, targets, applied duties and compare values are 0; all channel FSMs in RUN.
//     cmd_ready goes to 1 on the first clock after reset release.
//   Counter: counts 0..PERIOD-1, then wraps to 0.
//     period_tick=1 exactly when cnt==PERIOD-1.
//   Command port:
//     cmd_ready = !estop, registered from estop; a 1-cycle lag is permitted.
//     On accept, tgt_duty[ch] and tgt_dir[ch] are written in that cycle; a later accept overwrites.
//     Channel index >= N_CH: accept, no state change.
//   Ramp, evaluated only on period_tick, per channel:
//     Uses the targets registered before this cycle; a command accepted in the tick cycle applies at the next tick.
//     RUN:   if tgt_dir==dir, duty moves toward tgt_duty by min(RAMP_STEP, |diff|); no overshoot, no wrap.
//            if tgt_dir!=dir, go to DECEL.
//     DECEL: duty decreases by min(RAMP_STEP, duty). When duty==0 at a tick, go to FLIP.
//            If tgt_dir returns to dir while in DECEL, go back to RUN (no flip).
//     FLIP:  dir<=tgt_dir at the next tick, duty stays 0 for that full period, then RUN.
//            Guarantees >=1 full zero period before reversal.
//   Compare: cmp[ch] = (PERIOD * duty_next) >> DUTY_W, computed at the tick in CNT_W+DUTY_W-bit arithmetic.
//     Latched for the whole next period (glitch-free).
//   Output: pwm[ch] registered from (cnt < cmp[ch]).
//     Single-cycle output latency from the counter.
//     duty=0 gives constant low; max duty gives high for cmp cycles out of PERIOD (never 100%).
//   at_target: combinational from registered state, updated the cycle after any duty/dir/target change.
//   estop high, synchronous:
//     - next clock: pwm=0, all applied duty, tgt_duty and cmp set to 0, FSMs in RUN, dir held.
//     - commands are refused while estop is high.
//     - after release, the counter continues uninterrupted; channels ramp from 0 only after new commands.
//   Reset mid-ramp: all state returns to reset values immediately (asynchronous); no partial ramp survives.
// STRUCTURE
//   Package motor_pkg:
//     - channel FSM enum {RUN, DECEL, FLIP}
//     - localparam PWM_PERIOD_25K=4000
//     - default DUTY_W/RAMP_STEP constants
//     - function duty_to_cmp()
//   Sub-module motor_pwm_channel (one per channel, generate loop):
//     - inputs: target registers, period_tick, cnt, estop
//     - holds: FSM, applied duty, dir, cmp
//     - outputs: pwm, dir, at_target
//   Top level: counter, period_tick, command decode, cmd_ready.
// TESTING
//   1. Default params, cmd ch0 duty=512 dir=0 -> duty rises by 8 per tick and reaches 512 after 64 ticks.
//      Then pwm[0] high for 2000 of 4000 cycles each period; at_target[0]=1.
//   2. ch1 running duty=64 dir=0, cmd duty=64 dir=1 -> duty 56,48..0 over 8 ticks, then one full zero period.
//      Then dir[1]=1, then ramp back to 64 over 8 ticks. pwm[1] never high while dir toggles.
//   3. Command accepted in the same cycle as period_tick -> ramp at that tick uses the old target; new target applies from the next tick.
//   4. estop raised mid-ramp at duty=200 -> pwm=0 next cycle, cmd_ready=0 while high.
//      After release, no output until a new command; ramp restarts from 0.
//   5. cmd_ch=3 with N_CH=2 -> handshake completes; no output, dir or at_target change.
//   6. Async reset asserted mid-period at duty=300 -> pwm/dir/period_tick=0 immediately, at_target all 1.
//      After release, the first period_tick occurs 4000 cycles later.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the multi-channel motor PWM driver.
package motor_pkg;

  // Per-channel ramp/reversal state.
  typedef enum logic [1:0] {
    CH_RUN   = 2'd0,
    CH_DECEL = 2'd1,
    CH_FLIP  = 2'd2
  } ch_state_e;

  // 100 MHz clock / 25 kHz PWM.
  localparam int PWM_PERIOD_25K = 4000;
  localparam int DEF_DUTY_W     = 10;
  localparam int DEF_RAMP_STEP  = 8;

  // Compare threshold for a duty value: (period * duty) >> duty_w.
  // The product always fits in CNT_W+DUTY_W bits because period < 2^CNT_W;
  // the wider intermediate only avoids any overflow for odd parameter sets.
  function automatic logic [63:0] duty_to_cmp(input int unsigned period,
                                              input int unsigned duty,
                                              input int unsigned duty_w);
    logic [63:0] prod;
    prod = 64'(period) * 64'(duty);
    return prod >> duty_w;
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One motor channel: slew-limited duty ramp, safe direction reversal,
// per-period latched compare value and registered PWM output.
module motor_pwm_channel
  import motor_pkg::*;
#(
  parameter int DUTY_W    = DEF_DUTY_W,
  parameter int CNT_W     = 12,
  parameter int PERIOD    = PWM_PERIOD_25K,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              estop,
  input  logic              period_tick,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              tgt_dir,
  output logic              pwm,
  output logic              dir,
  output logic              at_target
);

  localparam int DUTY_MAX = (1 << DUTY_W) - 1;
  localparam logic [DUTY_W-1:0] STEP =
    DUTY_W'((RAMP_STEP > DUTY_MAX) ? DUTY_MAX : RAMP_STEP);

  ch_state_e         state, state_next;
  logic [DUTY_W-1:0] duty, duty_next;
  logic              dir_next;
  logic [CNT_W-1:0]  cmp, cmp_next;

  // Distances toward the target; each is only used in the branch where it
  // cannot underflow, so steps never overshoot or wrap.
  logic [DUTY_W-1:0] up_diff, dn_diff, up_step, dn_tgt_step, dn_zero_step;
  assign up_diff      = tgt_duty - duty;
  assign dn_diff      = duty - tgt_duty;
  assign up_step      = (up_diff > STEP) ? STEP : up_diff;
  assign dn_tgt_step  = (dn_diff > STEP) ? STEP : dn_diff;
  assign dn_zero_step = (duty > STEP) ? STEP : duty;

  // Next ramp state, applied only on period_tick.
  always_comb begin
    state_next = state;
    duty_next  = duty;
    dir_next   = dir;
    unique case (state)
      CH_RUN: begin
        if (tgt_dir != dir) begin
          // Reversal requested: start braking in this same tick.
          state_next = CH_DECEL;
          duty_next  = duty - dn_zero_step;
        end else if (tgt_duty > duty) begin
          duty_next = duty + up_step;
        end else begin
          duty_next = duty - dn_tgt_step;
        end
      end
      CH_DECEL: begin
        if (tgt_dir == dir)  state_next = CH_RUN;
        else if (duty == '0) state_next = CH_FLIP;
        else                 duty_next  = duty - dn_zero_step;
      end
      CH_FLIP: begin
        // Duty already held at zero for a full period; now swap direction.
        dir_next   = tgt_dir;
        state_next = CH_RUN;
      end
      default: state_next = CH_RUN;
    endcase
  end

  assign cmp_next  = CNT_W'(duty_to_cmp(PERIOD, 32'(duty_next), DUTY_W));
  assign at_target = (duty == tgt_duty) && (dir == tgt_dir);

  // Ramp state, compare latch and PWM output; estop zeroes drive but keeps dir.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CH_RUN;
      duty  <= '0;
      dir   <= 1'b0;
      cmp   <= '0;
      pwm   <= 1'b0;
    end else if (estop) begin
      state <= CH_RUN;
      duty  <= '0;
      cmp   <= '0;
      pwm   <= 1'b0;
    end else begin
      if (period_tick) begin
        state <= state_next;
        duty  <= duty_next;
        dir   <= dir_next;
        cmp   <= cmp_next;
      end
      pwm <= (cnt < cmp);
    end
  end

endmodule

// File: rtl/motor_pwm_multi.sv
// N-channel motor PWM driver: shared period counter, command decode into
// per-channel target registers, and one ramping channel per motor.
module motor_pwm_multi
  import motor_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DUTY_W    = DEF_DUTY_W,
  parameter int CNT_W     = 12,
  parameter int PERIOD    = PWM_PERIOD_25K,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cmd_ch,
  input  logic [DUTY_W-1:0]                       cmd_duty,
  input  logic                                    cmd_dir,
  input  logic                                    estop,
  output logic [N_CH-1:0]                         pwm,
  output logic [N_CH-1:0]                         dir,
  output logic [N_CH-1:0]                         at_target,
  output logic                                    period_tick
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CNT_W-1:0]             cnt;
  logic [N_CH-1:0][DUTY_W-1:0]  tgt_duty;
  logic [N_CH-1:0]              tgt_dir;
  logic                         accept;

  assign period_tick = (cnt == CNT_W'(PERIOD - 1));
  assign accept      = cmd_valid && cmd_ready;

  // Free-running period counter; estop does not disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (period_tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // Ready follows estop with one cycle of lag; low during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cmd_ready <= 1'b0;
    else       cmd_ready <= !estop;
  end

  // Target registers; out-of-range channel indices are accepted and dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_duty <= '0;
      tgt_dir  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (estop) begin
          tgt_duty[i] <= '0;
        end else if (accept && (cmd_ch == CH_W'(i))) begin
          tgt_duty[i] <= cmd_duty;
          tgt_dir[i]  <= cmd_dir;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    motor_pwm_channel #(
      .DUTY_W   (DUTY_W),
      .CNT_W    (CNT_W),
      .PERIOD   (PERIOD),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .estop      (estop),
      .period_tick(period_tick),
      .cnt        (cnt),
      .tgt_duty   (tgt_duty[g]),
      .tgt_dir    (tgt_dir[g]),
      .pwm        (pwm[g]),
      .dir        (dir[g]),
      .at_target  (at_target[g])
    );
  end

endmodule
